// File: rtl/ws2812b_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws2812b_pkg                                                      |
// | Purpose  : Shared definitions for the WS2812B receiver: decoder state       |
// |            encoding, default line-timing constants (in clk cycles at        |
// |            64 MHz) and a saturating counter helper.                         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ws2812b_pkg;

    // Default line timing at 64 MHz: T0H ~26 cycles, T1H ~51 cycles.
    localparam int unsigned c_BIT_THRESH   = 38;
    localparam int unsigned c_MAX_HIGH     = 96;
    localparam int unsigned c_RESET_CYCLES = 3200;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } rx_state_t;

    // 12-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [11:0] sat_inc12(input logic [11:0] value);
        return (value == 12'hFFF) ? value : value + 12'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812b_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws2812b_rx_sync                                                  |
// | Purpose  : Two-flop synchronizer for the asynchronous WS2812B line plus      |
// |            single-cycle rise/fall strobes on the synchronized signal.       |
// | Ports    : clk     - clock                                                  |
// |            reset   - synchronous active-high reset                          |
// |            i_din   - raw asynchronous serial line                           |
// |            o_din_s - synchronized line                                      |
// |            o_rise  - high in the first cycle o_din_s is 1 after being 0     |
// |            o_fall  - high in the first cycle o_din_s is 0 after being 1     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ws2812b_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_din_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_din_s = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/ws2812b_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws2812b_rx                                                       |
// | Purpose  : WS2812B single-wire receiver. Measures each high pulse on the    |
// |            synchronized line, decodes 24-bit GRB words MSB first, detects   |
// |            the reset/latch gap and flags malformed traffic.                 |
// | Ports    : clk         - clock, all logic on the rising edge                |
// |            reset       - synchronous active-high reset                      |
// |            din         - asynchronous serial input                          |
// |            data_out    - last received pixel {G,R,B}                        |
// |            valid       - 1-cycle pulse, data_out updated                    |
// |            latch       - 1-cycle pulse, reset gap detected                  |
// |            error       - 1-cycle pulse, overlong high or partial word       |
// |            pixel_count - words since last latch, saturating at 255          |
// |            dout        - forwarded line to the next device                  |
// | Config   : WS2812B_RX_FORWARD_EN - when defined, dout carries the           |
// |            synchronized line once the first pixel has been consumed;        |
// |            otherwise dout is tied low.                                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int unsigned BIT_THRESH   = c_BIT_THRESH,
    parameter int unsigned MAX_HIGH     = c_MAX_HIGH,
    parameter int unsigned RESET_CYCLES = c_RESET_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        valid,
    output logic        latch,
    output logic        error,
    output logic [7:0]  pixel_count,
    output logic        dout
);

    localparam logic [11:0] c_THRESH = BIT_THRESH[11:0];
    localparam logic [11:0] c_MAXH   = MAX_HIGH[11:0];
    localparam logic [11:0] c_GAP    = RESET_CYCLES[11:0];

    logic        w_din_s;
    logic        w_rise;
    logic        w_fall;

    rx_state_t   r_state,    w_state_nxt;
    logic [11:0] r_high_cnt, w_high_nxt;
    logic [11:0] r_low_cnt,  w_low_nxt;
    logic [4:0]  r_bit_cnt,  w_bit_nxt;
    logic [22:0] r_shift,    w_shift_nxt;
    logic [23:0] r_data,     w_data_nxt;
    logic [7:0]  r_pix,      w_pix_nxt;
    logic        r_valid,    w_valid_nxt;
    logic        r_latch,    w_latch_nxt;
    logic        r_error,    w_error_nxt;

    logic [11:0] w_low_inc;
    logic [11:0] w_high_inc;
    logic        w_bit;

    ws2812b_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_din   (din),
        .o_din_s (w_din_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SYNC;
            r_high_cnt <= 12'd0;
            r_low_cnt  <= 12'd0;
            r_bit_cnt  <= 5'd0;
            r_shift    <= 23'd0;
            r_data     <= 24'd0;
            r_pix      <= 8'd0;
            r_valid    <= 1'b0;
            r_latch    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_high_cnt <= w_high_nxt;
            r_low_cnt  <= w_low_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_pix      <= w_pix_nxt;
            r_valid    <= w_valid_nxt;
            r_latch    <= w_latch_nxt;
            r_error    <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_high_nxt  = r_high_cnt;
        w_low_nxt   = r_low_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_pix_nxt   = r_pix;
        w_valid_nxt = 1'b0;
        w_latch_nxt = 1'b0;
        w_error_nxt = 1'b0;

        w_low_inc   = sat_inc12(r_low_cnt);
        w_high_inc  = sat_inc12(r_high_cnt);
        // r_high_cnt equals the full high time in the fall cycle.
        w_bit       = (r_high_cnt >= c_THRESH);

        case (r_state)
            // Wait for a clean reset gap before trusting any bit boundary.
            ST_SYNC: begin
                if (w_din_s) begin
                    w_low_nxt = 12'd0;
                end else if (w_low_inc >= c_GAP) begin
                    w_low_nxt   = 12'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_low_nxt = w_low_inc;
                end
            end

            ST_IDLE: begin
                if (w_rise) begin
                    w_high_nxt  = 12'd1;
                    w_state_nxt = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (w_fall) begin
                    // The fall cycle is already the first low cycle.
                    w_low_nxt   = 12'd1;
                    w_state_nxt = ST_LOW;
                    if (r_bit_cnt == 5'd23) begin
                        w_data_nxt  = {r_shift, w_bit};
                        w_valid_nxt = 1'b1;
                        w_bit_nxt   = 5'd0;
                        w_pix_nxt   = (r_pix == 8'hFF) ? r_pix : r_pix + 8'd1;
                    end else begin
                        w_shift_nxt = {r_shift[21:0], w_bit};
                        w_bit_nxt   = r_bit_cnt + 5'd1;
                    end
                end else if (r_high_cnt >= c_MAXH) begin
                    // Line is still high and this cycle pushes the pulse past MAX_HIGH.
                    w_error_nxt = 1'b1;
                    w_bit_nxt   = 5'd0;
                    w_shift_nxt = 23'd0;
                    w_low_nxt   = 12'd0;
                    w_state_nxt = ST_SYNC;
                end else begin
                    w_high_nxt = w_high_inc;
                end
            end

            ST_LOW: begin
                if (w_rise) begin
                    w_high_nxt  = 12'd1;
                    w_state_nxt = ST_HIGH;
                end else if (w_low_inc >= c_GAP) begin
                    w_latch_nxt = 1'b1;
                    w_error_nxt = (r_bit_cnt != 5'd0);
                    w_pix_nxt   = 8'd0;
                    w_bit_nxt   = 5'd0;
                    w_shift_nxt = 23'd0;
                    w_low_nxt   = 12'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_low_nxt = w_low_inc;
                end
            end

            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    assign data_out    = r_data;
    assign valid       = r_valid;
    assign latch       = r_latch;
    assign error       = r_error;
    assign pixel_count = r_pix;

`ifdef WS2812B_RX_FORWARD_EN
    // The first pixel is ours; everything after it is passed downstream.
    assign dout = (r_pix != 8'd0) ? w_din_s : 1'b0;
`else
    assign dout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ws2812b_rx.md
WS2812B_RX -- requirements
Module: ws2812b_rx

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 38, high-time cycles at or above which a bit decodes as 1 (64 MHz: T0H 26, T1H 51).
REQ-002 SHALL have parameter MAX_HIGH, default 96, high-time cycles above which the pulse is an error.
REQ-003 SHALL have parameter RESET_CYCLES, default 3200, low-time cycles that constitute a frame reset/latch (50 us).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  1  asynchronous WS2812B serial line.
REQ-007 data_out  output  24  last received pixel, GRB, G in [23:16], R in [15:8], B in [7:0].
REQ-008 valid  output  1  one-cycle pulse: data_out updated.
REQ-009 latch  output  1  one-cycle pulse: reset gap detected.
REQ-010 error  output  1  one-cycle pulse: malformed bit or partial word.
REQ-011 pixel_count  output  8  words received since last latch, saturating at 255.
REQ-012 dout  output  1  forwarded line to next device.

Function
REQ-013 din SHALL pass a 2-flop synchronizer; all decoding uses synchronized din_s.
REQ-014 States: SYNC, IDLE, HIGH, LOW.
REQ-015 SYNC: count consecutive low cycles; at RESET_CYCLES go to IDLE, no latch pulse; any high clears the count.
REQ-016 IDLE/LOW to HIGH on din_s rising edge; high counter starts at 1.
REQ-017 HIGH: on falling edge, bit = (high_count >= BIT_THRESH), shifted in MSB first; go to LOW.
REQ-018 HIGH count exceeding MAX_HIGH SHALL pulse error, discard partial word, go to SYNC.
REQ-019 On the 24th bit, data_out and valid SHALL update in the cycle after the falling edge appears on din_s; bit counter wraps to 0; pixel_count increments.
REQ-020 LOW: low count reaching RESET_CYCLES SHALL pulse latch, clear pixel_count and bit counter, go to IDLE.
REQ-021 Latch with a nonzero bit counter SHALL also pulse error in the same cycle; the partial word is dropped.
REQ-022 Counters SHALL be 12 bits, saturating; no wrap.
REQ-023 data_out SHALL hold between valid pulses and is unaffected by latch or error.
REQ-024 valid, latch and error are mutually independent; valid and latch never coincide by construction.

Reset
REQ-025 Reset SHALL force SYNC, data_out=0, valid=0, latch=0, error=0, pixel_count=0, dout=0, counters and shift register cleared.
REQ-026 Reset mid-word SHALL discard the word; decoding resumes only after a full RESET_CYCLES low gap.

Configuration
REQ-027 With WS2812B_RX_FORWARD_EN defined, dout SHALL equal din_s while pixel_count >= 1 and 0 otherwise, so the first pixel is consumed and the rest are passed downstream.
REQ-028 Without WS2812B_RX_FORWARD_EN, dout SHALL be constant 0 and the forwarding logic SHALL be absent.

Structure
REQ-029 Package ws2812b_pkg SHALL hold the state enum and the default timing constants (BIT_THRESH, MAX_HIGH, RESET_CYCLES).
REQ-030 Sub-module ws2812b_rx_sync SHALL implement the synchronizer and the rise/fall edge detect.

Verification
REQ-031 Bench drives din, no prior gap, then 3200-cycle low, then 0xFF0080 bits (T1H 51/T0H 26, 80-cycle period) -> no valid before the gap; one valid with data_out=0xFF0080, pixel_count=1.
REQ-032 Bench sends 3 words 0x123456, 0xABCDEF, 0x000001, then a 3200-cycle low -> 3 valid pulses, then latch; pixel_count returns to 0.
REQ-033 Bench sends a 120-cycle high pulse mid-word -> error pulse, state SYNC, no valid until a fresh 3200-cycle gap.
REQ-034 Bench sends 10 bits then a 3200-cycle low -> latch and error in the same cycle; data_out unchanged.
REQ-035 Bench sends high times of 37 and 38 cycles -> decode as 0 and 1 respectively.
REQ-036 With WS2812B_RX_FORWARD_EN, bench sends 2 words -> dout is low for word 1 and mirrors din_s (2-cycle delay) for word 2; without the macro, dout stays 0 throughout.
